// File: rtl/joystick_spi_scheduler.sv
// joystick_spi_scheduler: round-robin SPI poller for two PmodJSTK joysticks on one shared bus.
// Each poll is a 5-byte mode-0 frame; decoded x/y/buttons are latched per player.
module joystick_spi_scheduler #(
    parameter int SCK_HALF  = 32,
    parameter int CS_SETUP  = 750,
    parameter int BYTE_GAP  = 500,
    parameter int FRAME_GAP = 50000,
    parameter int CW        = 16
) (
    input  logic       clk50M,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] led,
    output logic [1:0] cs,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic [9:0] x0,
    output logic [9:0] y0,
    output logic [9:0] x1,
    output logic [9:0] y1,
    output logic [2:0] btn0,
    output logic [2:0] btn1,
    output logic [1:0] update,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD, FGAP} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          dev_q, sck_q, mosi_q, cnt_zero;
    logic [2:0]    bit_q, byte_q, btn0_q, btn1_q;
    logic [6:0]    tx_q;
    logic [7:0]    rx_q, tx0;
    logic [9:0]    px_q, py_q, x0_q, y0_q, x1_q, y1_q;
    logic [1:0]    cs_q, update_q, sel;
    assign tx0      = {6'b100000, dev_q ? led[3:2] : led[1:0]};
    assign sel      = dev_q ? 2'b01 : 2'b10;
    assign cnt_zero = cnt_q == '0;
    assign cs     = cs_q;
    assign sck    = sck_q;
    assign mosi   = mosi_q;
    assign x0     = x0_q;
    assign y0     = y0_q;
    assign x1     = x1_q;
    assign y1     = y1_q;
    assign btn0   = btn0_q;
    assign btn1   = btn1_q;
    assign update = update_q;
    assign busy   = cs_q != 2'b11;
    always_ff @(posedge clk50M) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dev_q    <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            bit_q    <= '0;
            byte_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            px_q     <= '0;
            py_q     <= '0;
            x0_q     <= 10'd512;
            y0_q     <= 10'd512;
            x1_q     <= 10'd512;
            y1_q     <= 10'd512;
            btn0_q   <= '0;
            btn1_q   <= '0;
            cs_q     <= 2'b11;
            update_q <= '0;
        end else begin
            update_q <= '0;
            if (!cnt_zero) cnt_q <= cnt_q - CW'(1);
            case (state_q)
                IDLE: if (enable) begin
                    cs_q    <= sel;
                    cnt_q   <= CW'(CS_SETUP - 1);
                    state_q <= SETUP;
                end
                SETUP: if (cnt_zero) begin
                    tx_q    <= tx0[6:0];
                    mosi_q  <= tx0[7];
                    bit_q   <= '0;
                    byte_q  <= '0;
                    cnt_q   <= CW'(SCK_HALF - 1);
                    state_q <= SHIFT;
                end
                SHIFT: if (cnt_zero) begin
                    cnt_q <= CW'(SCK_HALF - 1);
                    sck_q <= ~sck_q;
                    if (!sck_q) rx_q <= {rx_q[6:0], miso};
                    else if (bit_q != 3'd7) begin
                        bit_q  <= bit_q + 3'd1;
                        tx_q   <= {tx_q[5:0], 1'b0};
                        mosi_q <= tx_q[6];
                    end else begin
                        mosi_q <= 1'b0;
                        // bytes 0-3 assemble the pending x/y; byte 4 (buttons) stays in rx_q
                        if (!byte_q[2] && byte_q[1]) py_q <= byte_q[0] ? {rx_q[1:0], py_q[7:0]} : {py_q[9:8], rx_q};
                        if (!byte_q[2] && !byte_q[1]) px_q <= byte_q[0] ? {rx_q[1:0], px_q[7:0]} : {px_q[9:8], rx_q};
                        if (byte_q == 3'd4) state_q <= HOLD;
                        else begin
                            cnt_q   <= CW'(BYTE_GAP - 1);
                            state_q <= GAP;
                        end
                    end
                end
                GAP: if (cnt_zero) begin
                    tx_q    <= '0;
                    mosi_q  <= 1'b0;
                    bit_q   <= '0;
                    byte_q  <= byte_q + 3'd1;
                    cnt_q   <= CW'(SCK_HALF - 1);
                    state_q <= SHIFT;
                end
                HOLD: if (cnt_zero) begin
                    cs_q <= 2'b11;
                    if (dev_q) {x1_q, y1_q, btn1_q} <= {px_q, py_q, rx_q[2:0]};
                    else {x0_q, y0_q, btn0_q} <= {px_q, py_q, rx_q[2:0]};
                    update_q <= ~sel;
                    dev_q    <= ~dev_q;
                    cnt_q    <= CW'(FRAME_GAP - 1);
                    state_q  <= FGAP;
                end
                FGAP: if (cnt_zero) begin
                    if (enable) begin
                        cs_q    <= sel;
                        cnt_q   <= CW'(CS_SETUP - 1);
                        state_q <= SETUP;
                    end else state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_joystick_spi_scheduler.sv
// tb_joystick_spi_scheduler: random-stimulus bench with a behavioural SPI slave/monitor
// and a frame-level reference model of the joystick scheduler.
module tb_joystick_spi_scheduler;
    localparam int SH = 2, CSU = 4, BG = 3, FG = 10;
    localparam int FLEN = CSU + 80 * SH + 4 * BG + SH;

    logic       clk50M = 1'b0, reset = 1'b1, enable = 1'b0, miso = 1'b0;
    logic [3:0] led = '0;
    logic [1:0] cs, update;
    logic       sck, mosi, busy;
    logic [9:0] x0, y0, x1, y1;
    logic [2:0] btn0, btn1;

    joystick_spi_scheduler #(.SCK_HALF(SH), .CS_SETUP(CSU), .BYTE_GAP(BG), .FRAME_GAP(FG), .CW(16)) dut (
        .clk50M(clk50M), .reset(reset), .enable(enable), .led(led), .cs(cs), .sck(sck),
        .mosi(mosi), .miso(miso), .x0(x0), .y0(y0), .x1(x1), .y1(y1), .btn0(btn0),
        .btn1(btn1), .update(update), .busy(busy)
    );

    always #5 clk50M = ~clk50M;

    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave responses and monitor snapshots
    logic [39:0] resp [2];
    logic [39:0] sh, mosi_sh, mon_resp, f_resp, f_mosi;
    logic [1:0]  prev_cs = 2'b11, f_upd;
    logic        prev_sck = 1'b0;
    logic [3:0]  mon_led, f_led;
    logic [9:0]  f_x [2], f_y [2];
    logic [2:0]  f_btn [2];
    int mon_dev, mon_bits = 0, mon_len, gap_len = 0, start_gap, f_dev, f_len, f_gap;
    int frames_done = 0, aborts = 0, upd_cycles = 0, cs00_cnt = 0, sck_idle_cnt = 0;

    always @(negedge clk50M) begin
        if (cs == 2'b00) cs00_cnt++;
        if (cs == 2'b11 && sck) sck_idle_cnt++;
        if (update != 2'b00) upd_cycles++;
        if (cs != 2'b11 && prev_cs == 2'b11) begin
            mon_dev   = cs[1] ? 0 : 1;
            mon_resp  = resp[mon_dev];
            sh        = mon_resp;
            miso      = sh[39];
            mon_bits  = 0;
            mon_len   = 0;
            mosi_sh   = '0;
            mon_led   = led;
            start_gap = gap_len;
        end
        if (cs != 2'b11) begin
            mon_len++;
            if (sck && !prev_sck) begin
                mosi_sh = {mosi_sh[38:0], mosi};
                mon_bits++;
            end
            if (!sck && prev_sck) begin
                sh   = {sh[38:0], 1'b0};
                miso = sh[39];
            end
        end else begin
            if (prev_cs != 2'b11) begin
                if (mon_bits == 40) begin
                    f_dev  = mon_dev;
                    f_len  = mon_len;
                    f_gap  = start_gap;
                    f_mosi = mosi_sh;
                    f_resp = mon_resp;
                    f_led  = mon_led;
                    f_upd  = update;
                    f_x[0] = x0; f_y[0] = y0; f_btn[0] = btn0;
                    f_x[1] = x1; f_y[1] = y1; f_btn[1] = btn1;
                    frames_done++;
                end else aborts++;
                mon_bits = 0;
                gap_len  = 0;
            end
            gap_len++;
        end
        prev_cs  = cs;
        prev_sck = sck;
    end

    // reference model: what each device's outputs should be after each completed frame
    logic [9:0] exp_x [2], exp_y [2];
    logic [2:0] exp_btn [2];
    int exp_dev;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_x[d] = 10'd512; exp_y[d] = 10'd512; exp_btn[d] = '0;
        end
        exp_dev = 0;
    endtask

    task automatic wait_frame();
        int n0 = frames_done;
        int i = 0;
        while (frames_done == n0 && i < 1000) begin
            @(posedge clk50M);
            i++;
        end
        check("frame_timeout", 40'(frames_done != n0), 40'd1);
    endtask

    task automatic wait_bits(input int n);
        int i = 0;
        while (mon_bits < n && i < 2000) begin
            @(posedge clk50M);
            i++;
        end
        check("bits_timeout", 40'(mon_bits >= n), 40'd1);
    endtask

    task automatic check_frame(input bit chk_gap);
        logic [39:0] r = f_resp;
        check("dev", 40'(f_dev), 40'(exp_dev));
        check("cs_len", 40'(f_len), 40'(FLEN));
        if (chk_gap) check("frame_gap", 40'(f_gap), 40'(FG));
        check("mosi_b0", 40'(f_mosi[39:32]), 40'({6'b100000, exp_dev == 1 ? f_led[3:2] : f_led[1:0]}));
        check("mosi_rest", 40'(f_mosi[31:0]), 40'd0);
        check("update", 40'(f_upd), exp_dev == 1 ? 40'd2 : 40'd1);
        exp_x[exp_dev]   = {r[25:24], r[39:32]};
        exp_y[exp_dev]   = {r[9:8], r[23:16]};
        exp_btn[exp_dev] = r[2:0];
        for (int d = 0; d < 2; d++) begin
            check($sformatf("x%0d", d), 40'(f_x[d]), 40'(exp_x[d]));
            check($sformatf("y%0d", d), 40'(f_y[d]), 40'(exp_y[d]));
            check($sformatf("btn%0d", d), 40'(f_btn[d]), 40'(exp_btn[d]));
        end
        exp_dev = 1 - exp_dev;
    endtask

    task automatic run_frame(input bit chk_gap);
        int u0 = upd_cycles;
        wait_frame();
        check_frame(chk_gap);
        repeat (3) @(posedge clk50M);
        check("upd_pulse", 40'(upd_cycles - u0), 40'd1);
    endtask

    task automatic rand_stim();
        for (int d = 0; d < 2; d++) resp[d] = {$urandom(), 8'($urandom())};
        led = 4'($urandom());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, u0;
        model_reset();
        resp[0] = 40'h34029A0105;
        resp[1] = 40'hFF03000007;
        led     = 4'b0011;
        repeat (3) @(negedge clk50M);
        check("rst_cs", 40'(cs), 40'd3);
        check("rst_sck", 40'(sck), 40'd0);
        check("rst_mosi", 40'(mosi), 40'd0);
        check("rst_update", 40'(update), 40'd0);
        check("rst_busy", 40'(busy), 40'd0);
        check("rst_x0", 40'(x0), 40'd512);
        check("rst_y0", 40'(y0), 40'd512);
        check("rst_x1", 40'(x1), 40'd512);
        check("rst_y1", 40'(y1), 40'd512);
        check("rst_btn0", 40'(btn0), 40'd0);
        check("rst_btn1", 40'(btn1), 40'd0);
        reset  = 1'b0;
        enable = 1'b1;
        run_frame(1'b0);
        check("dir_len", 40'(f_len), 40'd178);
        check("dir_x0", 40'(f_x[0]), 40'h234);
        check("dir_y0", 40'(f_y[0]), 40'h19A);
        check("dir_btn0", 40'(f_btn[0]), 40'd5);
        check("dir_mosi0", f_mosi, 40'h8300000000);
        run_frame(1'b1);
        check("dir_x1", 40'(f_x[1]), 40'h3FF);
        check("dir_y1", 40'(f_y[1]), 40'h000);
        check("dir_btn1", 40'(f_btn[1]), 40'd7);
        check("dir_mosi1", f_mosi, 40'h8000000000);
        check("dir_x0_hold", 40'(f_x[0]), 40'h234);
        for (int k = 0; k < 6; k++) begin
            rand_stim();
            if (k == 2) begin
                wait_bits(17);
                @(negedge clk50M);
                enable = 1'b0;
                run_frame(1'b1);
                n = frames_done;
                repeat (30) @(negedge clk50M);
                check("idle_cs", 40'(cs), 40'd3);
                check("idle_frames", 40'(frames_done), 40'(n));
                enable = 1'b1;
            end else run_frame(k != 3);
        end
        rand_stim();
        wait_bits(26);
        u0 = upd_cycles;
        @(negedge clk50M);
        reset = 1'b1;
        @(negedge clk50M);
        check("mid_cs", 40'(cs), 40'd3);
        check("mid_sck", 40'(sck), 40'd0);
        check("mid_update", 40'(update), 40'd0);
        check("mid_busy", 40'(busy), 40'd0);
        check("mid_x0", 40'(x0), 40'd512);
        check("mid_y0", 40'(y0), 40'd512);
        check("mid_x1", 40'(x1), 40'd512);
        check("mid_y1", 40'(y1), 40'd512);
        check("mid_btn", 40'({btn1, btn0}), 40'd0);
        reset = 1'b0;
        model_reset();
        @(negedge clk50M);
        check("mid_no_strobe", 40'(upd_cycles), 40'(u0));
        run_frame(1'b0);
        check("cs00_seen", 40'(cs00_cnt), 40'd0);
        check("sck_idle_high", 40'(sck_idle_cnt), 40'd0);
        check("aborts", 40'(aborts), 40'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
